rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Single-cycle arbiter sharing the 1024×32 instruction ROM between two requesters: the fetch stage (IF) and a debug/loader read port (DBG). It drives the ROM address combinationally from the winning requester and registers the ROM data. The data returns to the winner one cycle after grant. IF has fixed priority; an optional starvation guard bounds DBG wait time. The block sits between the PC/fetch logic and the ROM.

## Interface
- ADDR_W, 10, ROM word-address width
- DATA_W, 32, ROM data width
- STARVE_LIMIT, 4, max consecutive denied DBG cycles before DBG is forced to win (≥1; used only with starvation guard)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; if_addr must be stable while asserted
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  if_rdata valid (registered)
- if_rdata  out  DATA_W  fetched word (registered)
- dbg_req  in  1  debug read request
- dbg_addr  in  ADDR_W  debug word address
- dbg_gnt  out  1  debug granted this cycle (combinational)
- dbg_rvalid  out  1  dbg_rdata valid (registered)
- dbg_rdata  out  DATA_W  debug word (registered)
- rom_addr  out  ADDR_W  to ROM address input
- rom_data_in  in  DATA_W  from ROM combinational data output

## Operation
- At most one grant per cycle. if_gnt and dbg_gnt are never both high.
- Grant rule without forcing: if_gnt = if_req. dbg_gnt = dbg_req & ~if_req.
- Forced DBG win (guard enabled, starve_cnt == STARVE_LIMIT, dbg_req high): dbg_gnt = 1, if_gnt = 0. IF retries the next cycle.
- rom_addr = dbg_gnt ? dbg_addr : if_addr. The default path is IF even when idle.
- Owner register `own` takes the values NONE, IF, or DBG. It is loaded every cycle from the grant.
  - own==IF: if_rvalid=1, if_rdata = value captured at the grant edge.
  - own==DBG: dbg_rvalid=1, dbg_rdata = value captured at the grant edge.
- rdata registers load only when their port is granted. Otherwise they hold their last value.
- Requesters may hold req across cycles. Each granted cycle is one independent access, so back-to-back accesses give one word per cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when dbg_req & ~dbg_gnt.
  - Clears on dbg_gnt or when dbg_req is low.
- Reset values:
  - Outputs: if_rvalid=0, dbg_rvalid=0, if_rdata=0, dbg_rdata=0.
  - Internal state: own=NONE, starve_cnt=0.
  - While rst is high: if_gnt=0 and dbg_gnt=0, and rom_addr=if_addr.

## Timing
- Cycle N: req high, gnt asserted combinationally, rom_addr valid. rom_data_in is sampled at the end of N.
- Cycle N+1: the winner's rvalid=1 and rdata holds the sampled word. Read latency is 1 cycle.
- rvalid is a one-cycle pulse per grant, with no backpressure. The requester must accept the data.
- Simultaneous if_req and dbg_req: IF wins, unless forcing is active.
- rst asserted in a grant cycle: the grant is suppressed and rvalid is 0 in the next cycle. In-flight data from a grant at N−1 is dropped if rst is high at the N edge.
- Starvation bound (guard enabled): with if_req held high, DBG is granted no later than STARVE_LIMIT+1 cycles after dbg_req rises.

## Configuration
- ROM_ARB_STARVE_EN defined:
  - starve_cnt and forced DBG win are present.
  - STARVE_LIMIT is honoured.
- Not defined:
  - Pure fixed priority with IF always winning; DBG can starve indefinitely.
  - No counter logic is present and STARVE_LIMIT is ignored.

## Structure
- Shared package rom_arb_pkg:
  - ADDR_W/DATA_W default constants.
  - Owner enum typedef rom_own_t (OWN_NONE, OWN_IF, OWN_DBG).
- One sub-module, rom_arb_starve_ctr: saturating counter with a `force` output. It is instantiated only under ROM_ARB_STARVE_EN.
- The ROM is external. The arbiter contains no memory.

## Test plan
The bench ROM model returns `rom_data_in = 32'hA5A50000 | rom_addr` for every scenario.
- Reset:
  - Stimulus: rst high for 3 cycles with both reqs high.
  - Required: both gnts 0, both rvalids 0, both rdatas 0; the first grant occurs the cycle after rst falls.
- Single IF read:
  - Stimulus: if_req with if_addr=10'h004 for one cycle.
  - Required: if_gnt=1 that cycle; next cycle if_rvalid=1 and if_rdata=32'hA5A50004; dbg_rvalid stays 0.
- Collision:
  - Stimulus: if_req with addr 10'h010 and dbg_req with addr 10'h3FF, both high at cycle N; if_req drops at N+1.
  - Required: IF granted at N and if_rdata=32'hA5A50010 at N+1; DBG granted at N+1 and dbg_rdata=32'hA5A503FF at N+2.
- Back-to-back:
  - Stimulus: IF addrs 0,1,2,3 on consecutive cycles.
  - Required: if_rvalid high for 4 consecutive cycles with data …00, …01, …02, …03.
- Starvation (ROM_ARB_STARVE_EN, STARVE_LIMIT=4):
  - Stimulus: if_req and dbg_req held high, dbg_addr=10'h020.
  - Required: dbg_gnt asserts on the 5th cycle with if_gnt=0 that cycle; dbg_rdata=32'hA5A50020 the next cycle; IF is granted again the cycle after.
- Starvation off (macro undefined, same stimulus for 20 cycles):
  - Required: dbg_gnt never asserts.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared constants, owner encoding and grant-to-owner helper for the ROM port arbiter.
package rom_arb_pkg;

  localparam int unsigned ROM_ADDR_W = 10;
  localparam int unsigned ROM_DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DBG  = 2'd2
  } rom_own_t;

  // Grants are mutually exclusive, so the order of the tests is immaterial.
  function automatic rom_own_t own_from_grant(input logic if_gnt, input logic dbg_gnt);
    if (dbg_gnt)     return OWN_DBG;
    else if (if_gnt) return OWN_IF;
    else             return OWN_NONE;
  endfunction

endpackage

// File: rtl/rom_arb_starve_ctr.sv
// Saturating count of consecutive denied DBG cycles; force_o makes DBG win once the limit is hit.
module rom_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req_i,
  input  logic dbg_gnt_i,
  output logic force_o
);

  localparam int unsigned          CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]     LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!dbg_req_i || dbg_gnt_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_o = dbg_req_i && (cnt_q == LIMIT);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port (IF fixed priority, DBG secondary) arbiter in front of an external 1024x32 ROM.
// Define ROM_ARB_STARVE_EN to add the DBG starvation guard (bounded DBG wait).
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ROM_ADDR_W,
  parameter int unsigned DATA_W       = ROM_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data_in
);

  rom_own_t          own_q, own_d;
  logic [DATA_W-1:0] if_rdata_q, dbg_rdata_q;
  logic              force_dbg;

`ifdef ROM_ARB_STARVE_EN
  rom_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .rst       (rst),
    .dbg_req_i (dbg_req),
    .dbg_gnt_i (dbg_gnt),
    .force_o   (force_dbg)
  );
`else
  assign force_dbg = 1'b0;
  // STARVE_LIMIT has no effect in the pure fixed-priority build.
  if (STARVE_LIMIT == 0) begin : g_starve_limit_unused
  end
`endif

  // Reset suppresses both grants so nothing is captured during or straight after reset.
  always_comb begin
    if_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (force_dbg)   dbg_gnt = 1'b1;
      else if (if_req) if_gnt  = 1'b1;
      else             dbg_gnt = dbg_req;
    end
  end

  assign rom_addr = dbg_gnt ? dbg_addr : if_addr;
  assign own_d    = own_from_grant(if_gnt, dbg_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      own_q       <= OWN_NONE;
      if_rdata_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      own_q <= own_d;
      if (if_gnt)  if_rdata_q  <= rom_data_in;
      if (dbg_gnt) dbg_rdata_q <= rom_data_in;
    end
  end

  assign if_rvalid  = (own_q == OWN_IF);
  assign dbg_rvalid = (own_q == OWN_DBG);
  assign if_rdata   = if_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter; ROM model returns 32'hA5A50000 | rom_addr.
module tb_rom_port_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, dbg_req;
  logic [ADDR_W-1:0] if_addr, dbg_addr;
  logic              if_gnt, dbg_gnt, if_rvalid, dbg_rvalid;
  logic [DATA_W-1:0] if_rdata, dbg_rdata, rom_data_in;
  logic [ADDR_W-1:0] rom_addr;

  int checks = 0;
  int errors = 0;

  rom_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .dbg_req     (dbg_req),
    .dbg_addr    (dbg_addr),
    .dbg_gnt     (dbg_gnt),
    .dbg_rvalid  (dbg_rvalid),
    .dbg_rdata   (dbg_rdata),
    .rom_addr    (rom_addr),
    .rom_data_in (rom_data_in)
  );

  always #5 clk = ~clk;

  assign rom_data_in = 32'hA5A5_0000 | {22'd0, rom_addr};

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req  = 1'b0;
    dbg_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; dbg_req = 1'b1; if_addr = 10'h007; dbg_addr = 10'h009;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_gnt !== 1'b0)     begin errors++; $display("FAIL reset_if_gnt[%0d]: got %b want 0", i, if_gnt); end
      checks++; if (dbg_gnt !== 1'b0)    begin errors++; $display("FAIL reset_dbg_gnt[%0d]: got %b want 0", i, dbg_gnt); end
      checks++; if (if_rvalid !== 1'b0)  begin errors++; $display("FAIL reset_if_rvalid[%0d]: got %b want 0", i, if_rvalid); end
      checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dbg_rvalid[%0d]: got %b want 0", i, dbg_rvalid); end
      checks++; if (if_rdata !== 32'd0)  begin errors++; $display("FAIL reset_if_rdata[%0d]: got %h want 0", i, if_rdata); end
      checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_dbg_rdata[%0d]: got %h want 0", i, dbg_rdata); end
      checks++; if (rom_addr !== 10'h007) begin errors++; $display("FAIL reset_rom_addr[%0d]: got %h want 007", i, rom_addr); end
    end
    rst = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b1)  begin errors++; $display("FAIL reset_first_if_gnt: got %b want 1", if_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL reset_first_dbg_gnt: got %b want 0", dbg_gnt); end
    tick();
    checks++; if (if_rvalid !== 1'b1)         begin errors++; $display("FAIL reset_first_if_rvalid: got %b want 1", if_rvalid); end
    checks++; if (if_rdata !== 32'hA5A50007)  begin errors++; $display("FAIL reset_first_if_rdata: got %h want a5a50007", if_rdata); end
    idle(2);
  endtask

  task automatic test_single_if();
    if_req = 1'b1; if_addr = 10'h004; dbg_req = 1'b0; dbg_addr = 10'h000;
    #1;
    checks++; if (if_gnt !== 1'b1)    begin errors++; $display("FAIL single_if_gnt: got %b want 1", if_gnt); end
    checks++; if (dbg_gnt !== 1'b0)   begin errors++; $display("FAIL single_dbg_gnt: got %b want 0", dbg_gnt); end
    checks++; if (rom_addr !== 10'h004) begin errors++; $display("FAIL single_rom_addr: got %h want 004", rom_addr); end
    tick();
    if_req = 1'b0;
    checks++; if (if_rvalid !== 1'b1)        begin errors++; $display("FAIL single_if_rvalid: got %b want 1", if_rvalid); end
    checks++; if (if_rdata !== 32'hA5A50004) begin errors++; $display("FAIL single_if_rdata: got %h want a5a50004", if_rdata); end
    checks++; if (dbg_rvalid !== 1'b0)       begin errors++; $display("FAIL single_dbg_rvalid: got %b want 0", dbg_rvalid); end
    tick();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL single_if_rvalid_pulse: got %b want 0", if_rvalid); end
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 10'h010; dbg_req = 1'b1; dbg_addr = 10'h3FF;
    #1;
    checks++; if (if_gnt !== 1'b1)  begin errors++; $display("FAIL coll_n_if_gnt: got %b want 1", if_gnt); end
    checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL coll_n_dbg_gnt: got %b want 0", dbg_gnt); end
    tick();
    if_req = 1'b0;
    #1;
    checks++; if (if_rvalid !== 1'b1)        begin errors++; $display("FAIL coll_if_rvalid: got %b want 1", if_rvalid); end
    checks++; if (if_rdata !== 32'hA5A50010) begin errors++; $display("FAIL coll_if_rdata: got %h want a5a50010", if_rdata); end
    checks++; if (dbg_gnt !== 1'b1)          begin errors++; $display("FAIL coll_n1_dbg_gnt: got %b want 1", dbg_gnt); end
    checks++; if (if_gnt !== 1'b0)           begin errors++; $display("FAIL coll_n1_if_gnt: got %b want 0", if_gnt); end
    checks++; if (rom_addr !== 10'h3FF)      begin errors++; $display("FAIL coll_rom_addr: got %h want 3ff", rom_addr); end
    tick();
    dbg_req = 1'b0;
    checks++; if (dbg_rvalid !== 1'b1)        begin errors++; $display("FAIL coll_dbg_rvalid: got %b want 1", dbg_rvalid); end
    checks++; if (dbg_rdata !== 32'hA5A503FF) begin errors++; $display("FAIL coll_dbg_rdata: got %h want a5a503ff", dbg_rdata); end
    checks++; if (if_rvalid !== 1'b0)         begin errors++; $display("FAIL coll_if_rvalid_n2: got %b want 0", if_rvalid); end
    idle(2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    if_req = 1'b1; if_addr = 10'h000; dbg_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp = 32'hA5A5_0000 | 32'(i);
      checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_if_rvalid[%0d]: got %b want 1", i, if_rvalid); end
      checks++; if (if_rdata !== exp)   begin errors++; $display("FAIL b2b_if_rdata[%0d]: got %h want %h", i, if_rdata, exp); end
      if (i < 3) if_addr = 10'(i + 1);
      else       if_req  = 1'b0;
      tick();
    end
    checks++; if (if_rvalid !== 1'b0)         begin errors++; $display("FAIL b2b_if_rvalid_end: got %b want 0", if_rvalid); end
    checks++; if (dbg_rvalid !== 1'b0)        begin errors++; $display("FAIL b2b_dbg_rvalid: got %b want 0", dbg_rvalid); end
    checks++; if (dbg_rdata !== 32'hA5A503FF) begin errors++; $display("FAIL b2b_dbg_rdata_hold: got %h want a5a503ff", dbg_rdata); end
    idle(1);
  endtask

`ifdef ROM_ARB_STARVE_EN
  task automatic test_starvation();
    if_req = 1'b1; if_addr = 10'h100; dbg_req = 1'b1; dbg_addr = 10'h020;
    #1;
    for (int c = 1; c <= 4; c++) begin
      checks++; if (if_gnt !== 1'b1)  begin errors++; $display("FAIL starve_if_gnt[c%0d]: got %b want 1", c, if_gnt); end
      checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL starve_dbg_gnt[c%0d]: got %b want 0", c, dbg_gnt); end
      tick();
    end
    checks++; if (dbg_gnt !== 1'b1)     begin errors++; $display("FAIL starve_forced_dbg_gnt: got %b want 1", dbg_gnt); end
    checks++; if (if_gnt !== 1'b0)      begin errors++; $display("FAIL starve_forced_if_gnt: got %b want 0", if_gnt); end
    checks++; if (rom_addr !== 10'h020) begin errors++; $display("FAIL starve_rom_addr: got %h want 020", rom_addr); end
    tick();
    checks++; if (dbg_rvalid !== 1'b1)        begin errors++; $display("FAIL starve_dbg_rvalid: got %b want 1", dbg_rvalid); end
    checks++; if (dbg_rdata !== 32'hA5A50020) begin errors++; $display("FAIL starve_dbg_rdata: got %h want a5a50020", dbg_rdata); end
    checks++; if (if_gnt !== 1'b1)            begin errors++; $display("FAIL starve_if_regrant: got %b want 1", if_gnt); end
    checks++; if (dbg_gnt !== 1'b0)           begin errors++; $display("FAIL starve_dbg_after: got %b want 0", dbg_gnt); end
    if_req = 1'b0; dbg_req = 1'b0;
    tick();
    checks++; if (if_rdata !== 32'hA5A50100) begin errors++; $display("FAIL starve_if_rdata: got %h want a5a50100", if_rdata); end
    idle(1);
  endtask
`else
  task automatic test_starvation();
    if_req = 1'b1; if_addr = 10'h100; dbg_req = 1'b1; dbg_addr = 10'h020;
    #1;
    for (int c = 1; c <= 20; c++) begin
      checks++; if (dbg_gnt !== 1'b0) begin errors++; $display("FAIL nostarve_dbg_gnt[c%0d]: got %b want 0", c, dbg_gnt); end
      tick();
    end
    checks++; if (dbg_rvalid !== 1'b0) begin errors++; $display("FAIL nostarve_dbg_rvalid: got %b want 0", dbg_rvalid); end
    idle(1);
  endtask
`endif

  task automatic test_reset_in_flight();
    rst = 1'b0; if_req = 1'b1; if_addr = 10'h055; dbg_req = 1'b0;
    #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rif_pre_gnt: got %b want 1", if_gnt); end
    tick();
    checks++; if (if_rdata !== 32'hA5A50055) begin errors++; $display("FAIL rif_pre_rdata: got %h want a5a50055", if_rdata); end
    rst = 1'b1;
    #1;
    checks++; if (if_gnt !== 1'b0) begin errors++; $display("FAIL rif_gnt_suppressed: got %b want 0", if_gnt); end
    tick();
    checks++; if (if_rvalid !== 1'b0)   begin errors++; $display("FAIL rif_if_rvalid: got %b want 0", if_rvalid); end
    checks++; if (if_rdata !== 32'd0)   begin errors++; $display("FAIL rif_if_rdata: got %h want 0", if_rdata); end
    checks++; if (dbg_rdata !== 32'd0)  begin errors++; $display("FAIL rif_dbg_rdata: got %h want 0", dbg_rdata); end
    rst = 1'b0; if_req = 1'b0;
    tick();
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL rif_if_rvalid_after: got %b want 0", if_rvalid); end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; dbg_req = 1'b0; if_addr = '0; dbg_addr = '0;
    test_reset();
    test_single_if();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
